// File: rtl/match_result_drain.sv
// Captures one result frame per rising edge of isMatching into a small frame FIFO, then
// streams each frame as NUM_REC records over valid/ready; outputs hold while stalled.
module match_result_drain #(
  parameter int NUM_REC = 10,
  parameter int REC_W   = 24,
  parameter int DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REC*REC_W-1:0] position,
  input  logic                     isMatching,
  output logic [REC_W-1:0]         outRecord,
  output logic [3:0]               outIndex,
  output logic                     outLast,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [15:0]              frameCount,
  output logic [7:0]               dropCount,
  output logic                     busy
);

  localparam int FRAME_W = NUM_REC * REC_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(NUM_REC - 1);

  logic [0:0]         r_state;
  logic               r_prev_match;
  logic [FRAME_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [FRAME_W-1:0] r_shift;
  logic [3:0]         r_index;
  logic [15:0]        r_frame_cnt;
  logic [7:0]         r_drop_cnt;

  logic w_capture;
  logic w_full;
  logic w_empty;
  logic w_send;
  logic w_xfer;
  logic w_at_last;
  logic w_done;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_capture = isMatching & ~r_prev_match;
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_send    = (r_state == S_SEND);
  assign w_xfer    = w_send & outReady;
  assign w_at_last = (r_index == LAST_IDX);
  assign w_done    = w_xfer & w_at_last;
  // Reload on the last-record transfer so consecutive frames stream without a bubble.
  assign w_pop     = ~w_empty & (~w_send | w_done);
  // A pop on the same edge frees the slot a capture into a full FIFO needs.
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev_match <= 1'b0;
    end else begin
      r_prev_match <= isMatching;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= position;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_index <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
      r_index <= '0;
      r_state <= S_SEND;
    end else if (w_done) begin
      r_state <= S_IDLE;
    end else if (w_xfer) begin
      r_shift <= r_shift >> REC_W;
      r_index <= r_index + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign outValid   = w_send;
  assign outRecord  = r_shift[REC_W-1:0];
  assign outIndex   = r_index;
  assign outLast    = w_send & w_at_last;
  assign frameCount = r_frame_cnt;
  assign dropCount  = r_drop_cnt;
  assign busy       = ~w_empty | w_send;

endmodule

// File: tb/tb_match_result_drain.sv
// Randomised and directed bench for match_result_drain, checked every cycle against a
// queue-based frame model plus literal expectations for the directed scenarios.
module tb_match_result_drain;

  localparam int NR    = 10;
  localparam int RW    = 24;
  localparam int FW    = NR * RW;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [FW-1:0] position = '0;
  logic          isMatching = 1'b0;
  logic          outReady = 1'b0;
  logic [RW-1:0] outRecord;
  logic [3:0]    outIndex;
  logic          outLast;
  logic          outValid;
  logic [15:0]   frameCount;
  logic [7:0]    dropCount;
  logic          busy;

  always #5 clock = ~clock;

  match_result_drain #(.NUM_REC(NR), .REC_W(RW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .position(position), .isMatching(isMatching),
    .outRecord(outRecord), .outIndex(outIndex), .outLast(outLast), .outValid(outValid),
    .outReady(outReady), .frameCount(frameCount), .dropCount(dropCount), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a bounded queue of frames plus the frame being sent.
  logic [FW-1:0] m_fifo[$];
  logic [FW-1:0] m_cur;
  int            m_idx;
  bit            m_send, m_prev;
  int            m_frames, m_drops;
  bit            mx, md, mp, mc;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_fifo.delete();
      m_cur = '0; m_idx = 0; m_send = 0; m_prev = 0; m_frames = 0; m_drops = 0;
    end else begin
      mx = m_send && outReady;
      md = mx && (m_idx == NR - 1);
      mp = (m_fifo.size() > 0) && (!m_send || md);
      mc = isMatching && !m_prev;
      if (md) m_frames = (m_frames + 1) % 65536;
      if (mp) begin
        m_cur = m_fifo.pop_front(); m_idx = 0; m_send = 1;
      end else if (md) begin
        m_send = 0;
      end else if (mx) begin
        m_idx++;
      end
      if (mc) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(position);
        else if (m_drops < 255) m_drops++;
      end
      m_prev = isMatching;
    end
  end

  logic [RW-1:0] log_rec[$];
  always @(posedge clock) begin
    if (!reset && outValid === 1'b1 && outReady) log_rec.push_back(outRecord);
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("outValid", 32'(outValid), 32'(m_send));
      chk("busy", 32'(busy), 32'(m_send || (m_fifo.size() > 0)));
      chk("frameCount", 32'(frameCount), 32'(m_frames));
      chk("dropCount", 32'(dropCount), 32'(m_drops));
      if (m_send) begin
        chk("outRecord", 32'(outRecord), 32'(m_cur[m_idx*RW +: RW]));
        chk("outIndex", 32'(outIndex), 32'(m_idx));
        chk("outLast", 32'(outLast), 32'(m_idx == NR - 1));
      end
    end
  end

  function automatic logic [FW-1:0] pattern_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < NR; k++) f[k*RW +: RW] = {12'(k + 1), 12'(k + 100)};
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[FW-1:0];
  endfunction

  task automatic do_reset();
    @(negedge clock); reset = 1'b1; isMatching = 1'b0; outReady = 1'b0;
    @(negedge clock); reset = 1'b0;
    log_rec.delete();
  endtask

  task automatic pulse(input logic [FW-1:0] f);
    @(negedge clock); position = f; isMatching = 1'b1;
    @(negedge clock); isMatching = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((busy || outValid) && n < max) begin @(negedge clock); n++; end
    chk({name, "_idle_timeout"}, 32'(busy | outValid), 32'd0);
  endtask

  task automatic chk_frames(input string name, input logic [FW-1:0] fr[$]);
    logic [FW-1:0] f;
    chk({name, "_nrec"}, 32'(log_rec.size()), 32'(fr.size() * NR));
    for (int i = 0; i < log_rec.size() && i < fr.size() * NR; i++) begin
      f = fr[i / NR];
      chk({name, "_rec"}, 32'(log_rec[i]), 32'(f[(i % NR)*RW +: RW]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] f;
  int            n;

  initial begin
    // Reset state while reset is held.
    @(negedge clock);
    chk("rst_outValid", 32'(outValid), 0);
    chk("rst_outLast", 32'(outLast), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outRecord", 32'(outRecord), 0);
    chk("rst_outIndex", 32'(outIndex), 0);
    chk("rst_frameCount", 32'(frameCount), 0);
    chk("rst_dropCount", 32'(dropCount), 0);
    @(negedge clock); reset = 1'b0;

    // 1: single pulse, latency of one cycle after the capture edge.
    log_rec.delete(); outReady = 1'b1;
    @(negedge clock); position = pattern_frame(); isMatching = 1'b1;
    @(negedge clock); chk("s1_valid_after_capture", 32'(outValid), 0); isMatching = 1'b0;
    @(negedge clock); chk("s1_valid_one_later", 32'(outValid), 1);
    wait_idle("s1", 200);
    chk("s1_nrec", 32'(log_rec.size()), 10);
    if (log_rec.size() >= 10) begin
      chk("s1_first_rec", 32'(log_rec[0]), 32'h001064);
      chk("s1_last_rec", 32'(log_rec[9]), 32'h00A06D);
    end
    chk("s1_frameCount", 32'(frameCount), 1);
    chk("s1_busy", 32'(busy), 0);

    // 2: level held for 50 cycles with a changing bus yields one frame from the edge.
    do_reset(); outReady = 1'b1;
    @(negedge clock); f = rand_frame(); position = f; isMatching = 1'b1;
    repeat (49) begin @(negedge clock); position = rand_frame(); end
    @(negedge clock); isMatching = 1'b0;
    wait_idle("s2", 200);
    exp_q = '{f};
    chk_frames("s2", exp_q);
    chk("s2_frameCount", 32'(frameCount), 1);

    // 3: ready pattern 1,0,0,1 repeating during a frame.
    do_reset();
    @(negedge clock); position = pattern_frame(); isMatching = 1'b1;
    n = 0;
    do begin
      @(negedge clock); isMatching = 1'b0;
      outReady = (n % 4 == 0) || (n % 4 == 3);
      n++;
    end while ((busy || outValid) && n < 200);
    chk("s3_timeout", 32'(busy | outValid), 0);
    exp_q = '{pattern_frame()};
    chk_frames("s3", exp_q);

    // 4: six captures with no ready: the first frame moves straight into the
    // serializer, the FIFO holds the next four, so only the sixth is dropped.
    do_reset(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      f = (i == 0) ? '0 : rand_frame();
      if (i < 5) exp_q.push_back(f);
      pulse(f);
    end
    chk("s4_dropCount", 32'(dropCount), 1);
    outReady = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (busy && n < 200);
    chk("s4_drain_cycles", 32'(n), 50);
    chk_frames("s4", exp_q);
    chk("s4_frameCount", 32'(frameCount), 5);

    // 5: capture on the same edge as the last-record transfer while the FIFO is full.
    do_reset(); exp_q.delete();
    for (int i = 0; i < 5; i++) begin f = rand_frame(); exp_q.push_back(f); pulse(f); end
    chk("s5_drop_before", 32'(dropCount), 0);
    outReady = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!(outValid && outIndex == 4'd9) && n < 50);
    chk("s5_reach_last_timeout", 32'(outValid && outIndex == 4'd9), 1);
    f = rand_frame(); exp_q.push_back(f); position = f; isMatching = 1'b1;
    @(negedge clock); isMatching = 1'b0;
    wait_idle("s5", 300);
    chk("s5_dropCount", 32'(dropCount), 0);
    chk("s5_frameCount", 32'(frameCount), 6);
    chk_frames("s5", exp_q);

    // 6: reset mid-frame with two frames queued.
    outReady = 1'b0; log_rec.delete();
    for (int i = 0; i < 3; i++) pulse(rand_frame());
    outReady = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (outIndex != 4'd5 && n < 50);
    chk("s6_reach_idx5", 32'(outIndex), 5);
    reset = 1'b1;
    #1;
    chk("s6_rst_outValid", 32'(outValid), 0);
    chk("s6_rst_frameCount", 32'(frameCount), 0);
    chk("s6_rst_dropCount", 32'(dropCount), 0);
    chk("s6_rst_busy", 32'(busy), 0);
    chk("s6_rst_outIndex", 32'(outIndex), 0);
    @(negedge clock); reset = 1'b0; log_rec.delete();
    repeat (30) @(negedge clock);
    chk("s6_no_records", 32'(log_rec.size()), 0);
    chk("s6_idle_busy", 32'(busy), 0);
    pulse(pattern_frame());
    wait_idle("s6", 200);
    exp_q = '{pattern_frame()};
    chk_frames("s6", exp_q);
    chk("s6_frameCount", 32'(frameCount), 1);

    // Drop counter saturation.
    do_reset();
    repeat (270) pulse(rand_frame());
    chk("sat_dropCount", 32'(dropCount), 255);

    // Random traffic against the model.
    do_reset();
    repeat (1500) begin
      @(negedge clock);
      isMatching = ($urandom % 4 == 0);
      outReady = ($urandom % 3 != 0);
      if ($urandom % 2 == 1) position = rand_frame();
    end
    @(negedge clock); isMatching = 1'b0; outReady = 1'b1;
    wait_idle("rand", 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
